// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared types and constants for the CPU front end:
//                fetch-state encoding, instruction width, jump opcode and
//                the NOP word used to fill bubbles.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int          INSTR_W  = 32;
    localparam logic [5:0]  OPC_J    = 6'b000010;
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    // FETCH: request in flight at pc
    // DROP : stale request completing, its data will be thrown away
    // HOLD : fetched word parked in the skid buffer while ID is stalled
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        DROP  = 2'd1,
        HOLD  = 2'd2
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/fetch_hold_buf.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_hold_buf
//  Description : One-entry skid register {valid, instr, pc4} that parks a
//                returned instruction while the ID stage is stalled.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_hold_buf
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_load,
    input  logic               i_clear,
    input  logic               i_take,
    input  logic [INSTR_W-1:0] i_instr,
    input  logic [ADDR_W-1:0]  i_pc4,
    output logic               o_valid,
    output logic [INSTR_W-1:0] o_instr,
    output logic [ADDR_W-1:0]  o_pc4
);

    logic               r_valid;
    logic [INSTR_W-1:0] r_instr;
    logic [ADDR_W-1:0]  r_pc4;

    // Clear wins over load; a take simply empties the entry.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_valid <= 1'b0;
            r_instr <= NOP_WORD;
            r_pc4   <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_instr <= i_instr;
            r_pc4   <= i_pc4;
        end else if (i_take) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_instr = r_instr;
    assign o_pc4   = r_pc4;

endmodule
`default_nettype wire

// File: rtl/fetch_redirect_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_redirect_unit
//  Description : Instruction-fetch stage. Owns the PC, the single-outstanding
//                instruction-memory handshake and the IF/ID register, and
//                steers the PC on taken branches (EX) and jumps (ID).
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_redirect_unit
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall_id,
    input  logic               ex_branch,
    input  logic               ex_reverse,
    input  logic               ex_zero,
    input  logic [ADDR_W-1:0]  ex_target,
    input  logic               id_jump,
    input  logic [ADDR_W-1:0]  id_jump_target,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               ifid_valid,
    output logic [INSTR_W-1:0] ifid_instr,
    output logic [ADDR_W-1:0]  ifid_pc4,
    output logic               flush
);

    fetch_state_t       r_state;
    logic [ADDR_W-1:0]  r_pc;
    logic [ADDR_W-1:0]  r_drop_addr;
    logic               r_ifid_valid;
    logic [INSTR_W-1:0] r_ifid_instr;
    logic [ADDR_W-1:0]  r_ifid_pc4;

    logic               w_br_taken;
    logic               w_jmp_taken;
    logic               w_flush;
    logic               w_accept;
    logic [ADDR_W-1:0]  w_target_raw;
    logic [ADDR_W-1:0]  w_target;
    logic [ADDR_W-1:0]  w_pc_plus4;
    logic               w_buf_load;
    logic               w_buf_clear;
    logic               w_buf_take;
    logic               w_buf_valid;
    logic [INSTR_W-1:0] w_buf_instr;
    logic [ADDR_W-1:0]  w_buf_pc4;

    // The EX branch is older than the ID jump, so it takes priority and
    // implicitly kills the jump sitting behind it.
    assign w_br_taken   = ex_branch & (ex_zero ^ ex_reverse);
    assign w_jmp_taken  = id_jump & r_ifid_valid & ~stall_id;
    assign w_flush      = w_br_taken | w_jmp_taken;
    assign w_target_raw = w_br_taken ? ex_target : id_jump_target;
    assign w_target     = {w_target_raw[ADDR_W-1:2], 2'b00};
    assign w_accept     = ~stall_id & ~w_flush;
    assign w_pc_plus4   = r_pc + ADDR_W'(4);

    assign w_buf_load   = (r_state == FETCH) & imem_ack & ~w_flush & stall_id;
    assign w_buf_clear  = (r_state == HOLD) & w_flush;
    assign w_buf_take   = (r_state == HOLD) & w_accept;

    // In DROP the address must stay on the abandoned request until it acks.
    assign imem_req   = ~reset & (r_state != HOLD);
    assign imem_addr  = (r_state == DROP) ? r_drop_addr : r_pc;
    assign flush      = w_flush;
    assign ifid_valid = r_ifid_valid;
    assign ifid_instr = r_ifid_instr;
    assign ifid_pc4   = r_ifid_pc4;

    fetch_hold_buf #(
        .ADDR_W (ADDR_W)
    ) u_hold_buf (
        .clk     (clk),
        .rst     (reset),
        .i_load  (w_buf_load),
        .i_clear (w_buf_clear),
        .i_take  (w_buf_take),
        .i_instr (imem_rdata),
        .i_pc4   (w_pc_plus4),
        .o_valid (w_buf_valid),
        .o_instr (w_buf_instr),
        .o_pc4   (w_buf_pc4)
    );

    // Fetch FSM: PC sequencing, redirects and the outstanding-request tracking.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= FETCH;
            r_pc        <= RESET_PC;
            r_drop_addr <= RESET_PC;
        end else begin
            if (w_flush) begin
                r_pc <= w_target;
            end
            case (r_state)
                FETCH: begin
                    if (w_flush) begin
                        if (!imem_ack) begin
                            r_state     <= DROP;
                            r_drop_addr <= r_pc;
                        end
                    end else if (imem_ack) begin
                        r_pc <= w_pc_plus4;
                        if (stall_id) begin
                            r_state <= HOLD;
                        end
                    end
                end
                DROP: begin
                    if (imem_ack) begin
                        r_state <= FETCH;
                    end
                end
                HOLD: begin
                    if (w_flush || w_accept) begin
                        r_state <= FETCH;
                    end
                end
                default: begin
                    r_state <= FETCH;
                end
            endcase
        end
    end

    // IF/ID register: flush clears it, stall freezes it, otherwise it takes
    // the fresh word, the parked word, or a bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ifid_valid <= 1'b0;
            r_ifid_instr <= NOP_WORD;
            r_ifid_pc4   <= '0;
        end else if (w_flush) begin
            r_ifid_valid <= 1'b0;
            r_ifid_instr <= NOP_WORD;
        end else if (w_accept) begin
            if ((r_state == FETCH) && imem_ack) begin
                r_ifid_valid <= 1'b1;
                r_ifid_instr <= imem_rdata;
                r_ifid_pc4   <= w_pc_plus4;
            end else if (r_state == HOLD) begin
                r_ifid_valid <= w_buf_valid;
                r_ifid_instr <= w_buf_instr;
                r_ifid_pc4   <= w_buf_pc4;
            end else begin
                r_ifid_valid <= 1'b0;
                r_ifid_instr <= NOP_WORD;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/fetch_redirect_unit.md
Name: fetch_redirect_unit

Overview:
- Instruction-fetch stage that produces the opcode stream consumed by the main decoder.
- Consumes the decoder's branch/jump/reverse control flags on their return path to steer the PC.
- Owns the PC register, the single-outstanding instruction-memory handshake and the IF/ID pipeline register.
- Handles hazard-unit stalls and branch/jump flushes.

Parameters:
- ADDR_W, 32, PC/address width in bits.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  single system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- stall_id  in  1  hazard unit: ID stage holds; IF/ID must not change.
- ex_branch  in  1  branch flag of the instruction now in EX (decoder branch output, pipelined).
- ex_reverse  in  1  decoder reverse flag, pipelined; 1 = BNE.
- ex_zero  in  1  ALU zero result for that instruction.
- ex_target  in  ADDR_W  branch target address.
- id_jump  in  1  decoder jump output for the instruction now in ID.
- id_jump_target  in  ADDR_W  computed as {ifid_pc4[31:28], instr[25:0], 2'b00}.
- imem_req  out  1  fetch request; held high until acknowledged.
- imem_addr  out  ADDR_W  word address, stable while imem_req=1.
- imem_ack  in  1  read done; may assert in the same cycle as imem_req.
- imem_rdata  in  32  instruction word, valid when imem_ack=1.
- ifid_valid  out  1  IF/ID holds a live instruction.
- ifid_instr  out  32  IF/ID instruction (opCode = [31:26]).
- ifid_pc4  out  ADDR_W  address of the instruction + 4.
- flush  out  1  combinational; high in any cycle a redirect is taken.

Behaviour:
- Redirect decode:
  - br_taken = ex_branch & (ex_zero ^ ex_reverse).
  - jmp_taken = id_jump & ifid_valid & ~stall_id.
  - br_taken has priority: it is older and kills the ID-stage jump.
  - redirect target = br_taken ? ex_target : id_jump_target.
  - flush = br_taken | jmp_taken.
- Reset: state=FETCH, pc=RESET_PC, ifid_valid=0, ifid_instr=0, ifid_pc4=0, holding buffer empty, imem_req=0 during the reset cycle.
  - Reset asserted mid-transaction abandons it; the memory must tolerate a dropped request.
- Position of the IF/ID register:
  - IF/ID "accepts" in a cycle when stall_id=0 and flush=0.
  - On flush: ifid_valid<=0 (instruction zeroed), regardless of stall.
- FETCH state (imem_req=1, imem_addr=pc):
  - flush & ~ack: pc<=target, state<=DROP.
  - flush & ack: returned word discarded; pc<=target; stay in FETCH.
  - ack & accepts: IF/ID <= {1, rdata, pc+4}; pc<=pc+4.
  - ack & stall_id: word and pc+4 go to the holding buffer; pc<=pc+4; state<=HOLD.
  - no ack: hold pc and address.
- DROP state: the outstanding request completes unaltered.
  - imem_req=1, imem_addr = latched old pc; the new target is held in pc.
  - On ack: discard data, state<=FETCH.
  - A further flush in DROP only updates pc.
- HOLD state: imem_req=0.
  - flush: buffer cleared, pc<=target, state<=FETCH.
  - accepts: IF/ID <= buffer, state<=FETCH.
- Latency: with zero-wait memory and no stalls, one instruction enters IF/ID per cycle. Branch penalty is 2 bubbles; jump penalty is 1 bubble.
- PC arithmetic: unsigned modulo 2^ADDR_W; 32'hFFFF_FFFC + 4 wraps to 0. Bits [1:0] of the target are forced to 0.
- Simultaneous stall_id and flush: flush wins.

Decomposition:
- Shared package cpu_pkg:
  - fetch-state encoding FETCH/DROP/HOLD (2 bits);
  - INSTR_W=32;
  - OPC_J=6'b000010 for the bench;
  - NOP word 32'h0000_0000.
- One natural sub-module: fetch_hold_buf, a one-entry skid register {valid, instr, pc4} with load/clear/take.

Test Plan:
1. Reset, then zero-wait ack with rdata = 0x20080005 at addr 0,4,8 -> ifid_instr follows one cycle after each ack; ifid_pc4 = 4, 8, 12; imem_addr 0, 4, 8.
2. stall_id=1 for 3 cycles while ack=1 at addr 8 -> state HOLD, imem_req=0, ifid unchanged. On release, ifid_instr = word@8 and the next fetch is addr 12.
3. ex_branch=1, ex_zero=1, ex_reverse=0, ex_target=0x40 -> flush=1, ifid_valid=0 next cycle, next imem_addr=0x40. Repeat with ex_reverse=1 -> no flush.
4. id_jump=1, id_jump_target=0x100, with ex_branch taken to 0x40 in the same cycle -> pc=0x40; the jump is ignored.
5. 3-wait-state memory with a branch redirect to 0x80 in wait cycle 1 -> imem_addr stays at the old pc until ack, returned data is discarded (ifid_valid=0), then imem_addr=0x80.
6. pc=0xFFFF_FFFC with ack -> ifid_pc4=0, next imem_addr=0. Reset asserted during DROP -> next cycle pc=RESET_PC, ifid_valid=0.
